keypad_4x4_scan: RTL and testbench

Scans a 4x4 matrix keypad and delivers one debounced hex key code per press. It is the input-side counterpart of the multiplexed 7-segment display path: the display time-multiplexes outputs across digit enables, and this block time-multiplexes inputs across keypad columns. The 4-bit code it produces feeds the stopwatch/display logic directly, for example the hex segment decoder or the control inputs.

---
 rtl/keypad_4x4_scan.sv | 185 ++++++++++++++++++
 tb/tb_keypad_4x4_scan.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_4x4_scan.sv
// keypad_4x4_scan
//   Scans a 4x4 active-low matrix keypad one column at a time. A full scan of
//   all four columns forms a frame. Each frame is classified as no key, a
//   single key, or several keys (ghosting, treated as no valid key). Press and
//   release are debounced over DB_FRAMES consecutive frames. One key code is
//   delivered per press.
//
// Parameters
//   SCAN_DIV  : clocks each column is driven low (>= 4)
//   DB_FRAMES : consecutive identical frames needed to accept a press or a
//               release (>= 2)
//
// Ports
//   clk       : system clock
//   clr_n     : asynchronous active-low reset
//   row[3:0]  : keypad rows, active-low, asynchronous to clk
//   col[3:0]  : column drives, active-low, exactly one bit low
//   key_code  : last accepted key, 4*row_index + col_index
//   key_valid : one-clock pulse when a new key is accepted
//   key_held  : high while the accepted key is still considered pressed
module keypad_4x4_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int DB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DB_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DB_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  logic [3:0]       row_p0;
  logic [3:0]       row_p1;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_index;
  logic [1:0]       col_index_next;
  logic [15:0]      snap;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [3:0]       cand;

  logic        tick;
  logic        frame_end;
  logic [15:0] frame;
  logic [4:0]  zeros;
  logic [3:0]  low_idx;
  logic        is_none;
  logic        is_single;

  assign tick           = (div == DIV_LAST);
  assign frame_end      = tick && (col_index == 2'd3);
  assign col_index_next = col_index + 2'd1;

  // Snapshot with the sample being taken on this clock merged in, so the
  // column-3 sample is part of the frame that is classified on the same edge.
  // Bit 4*r+c holds row r seen while column c was driven.
  always_comb begin
    frame   = snap;
    zeros   = 5'd0;
    low_idx = 4'd0;
    for (int r = 0; r < 4; r++) begin
      frame[{r[1:0], col_index}] = row_p1[r];
    end
    for (int k = 0; k < 16; k++) begin
      if (!frame[k]) begin
        zeros   = zeros + 5'd1;
        low_idx = k[3:0];
      end
    end
  end

  assign is_none   = (zeros == 5'd0);
  assign is_single = (zeros == 5'd1);

  // Saturating frame counter increment; never wraps past DB_FRAMES.
  assign cnt_next = (cnt == CNT_DONE) ? cnt : cnt + 1'b1;

  // Stage p0/p1: two-flop synchronizer for the asynchronous rows
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      row_p0 <= 4'hF;
      row_p1 <= 4'hF;
    end else begin
      row_p0 <= row;
      row_p1 <= row_p0;
    end
  end

  // Column scan: divider, column drive and frame snapshot
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div       <= '0;
      col_index <= 2'd0;
      col       <= 4'b1110;
      snap      <= 16'hFFFF;
    end else if (tick) begin
      div       <= '0;
      col_index <= col_index_next;
      col       <= ~(4'b0001 << col_index_next);
      snap      <= frame;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Debounce FSM, evaluated once per frame end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cand      <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        case (state)
          S_IDLE: begin
            if (is_single) begin
              cand  <= low_idx;
              cnt   <= CNT_W'(1);
              state <= S_DEBOUNCE;
            end
          end
          S_DEBOUNCE: begin
            if (is_single && (low_idx == cand)) begin
              cnt <= cnt_next;
              if (cnt_next == CNT_DONE) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= '0;
                state     <= S_PRESSED;
              end
            end else begin
              cnt   <= '0;
              state <= S_IDLE;
            end
          end
          S_PRESSED: begin
            // Other keys or ghosting are ignored until a clean release.
            if (is_none) begin
              cnt   <= CNT_W'(1);
              state <= S_RELEASE;
            end
          end
          S_RELEASE: begin
            if (is_none) begin
              cnt <= cnt_next;
              if (cnt_next == CNT_DONE) begin
                key_held <= 1'b0;
                cnt      <= '0;
                state    <= S_IDLE;
              end
            end else begin
              cnt   <= '0;
              state <= S_PRESSED;
            end
          end
          default: begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_4x4_scan.sv
// tb_keypad_4x4_scan
//   Directed bench for keypad_4x4_scan with SCAN_DIV=4, DB_FRAMES=3 (16-clock
//   frames). A combinational keypad model pulls row[r] low whenever a pressed
//   key in row r sits on the currently driven column. Key changes are applied
//   at frame boundaries so every frame sees a clean pattern.
module tb_keypad_4x4_scan;

  localparam int SCAN_DIV  = 4;
  localparam int DB_FRAMES = 3;
  localparam int FRAME     = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         f_pulses;
  int         f_pos;
  logic [3:0] f_code;
  logic       f_held;

  always #5 clk = ~clk;

  keypad_4x4_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DB_FRAMES(DB_FRAMES)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[{r[1:0], c[1:0]}] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Runs one frame, recording pulses, pulse position (1..16) and code.
  task automatic step_frame();
    f_pulses = 0;
    f_pos    = 0;
    f_code   = 4'hX;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) begin
        f_pulses++;
        f_pos  = i;
        f_code = key_code;
      end
    end
    f_held = key_held;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  // Runs n frames with a constant key pattern; expects a single pulse with
  // code exp_code at the end of frame pulse_f (0 = no pulse), and key_held
  // at each frame end to be 1 from held_from up to held_to inclusive.
  task automatic run_frames(input string nm, input logic [15:0] k, input int n,
                            input int pulse_f, input logic [3:0] exp_code,
                            input int held_from, input int held_to);
    keys = k;
    for (int f = 1; f <= n; f++) begin
      step_frame();
      n_cmp++;
      if (f_pulses !== ((f == pulse_f) ? 1 : 0)) begin
        n_bad++;
        $display("FAIL %s_f%0d_pulses: got %0d want %0d", nm, f, f_pulses, (f == pulse_f) ? 1 : 0);
      end
      if (f == pulse_f) begin
        n_cmp++;
        if (f_pos !== FRAME) begin
          n_bad++;
          $display("FAIL %s_f%0d_pulse_pos: got %0d want %0d", nm, f, f_pos, FRAME);
        end
        n_cmp++;
        if (f_code !== exp_code) begin
          n_bad++;
          $display("FAIL %s_f%0d_code: got %0d want %0d", nm, f, f_code, exp_code);
        end
      end
      n_cmp++;
      if (f_held !== ((f >= held_from) && (f <= held_to))) begin
        n_bad++;
        $display("FAIL %s_f%0d_held: got %b want %b", nm, f, f_held, (f >= held_from) && (f <= held_to));
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    keys  = 16'h0000;
    clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (col !== 4'b1110) begin n_bad++; $display("FAIL reset_col: got %b want 1110", col); end
    n_cmp++;
    if (key_code !== 4'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", key_code); end
    n_cmp++;
    if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
    n_cmp++;
    if (key_held !== 1'b0) begin n_bad++; $display("FAIL reset_held: got %b want 0", key_held); end
    @(negedge clk);
    clr_n = 1'b1;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      #1;
      exp_col = ~(4'b0001 << ((i / SCAN_DIV) % 4));
      n_cmp++;
      if (col !== exp_col) begin
        n_bad++;
        $display("FAIL scan_col_clk%0d: got %b want %b", i, col, exp_col);
      end
    end
  endtask

  task automatic test_clean_press();
    keys = 16'h0000;
    do_reset();
    run_frames("clean_hold", 16'h0200, 10, 3, 4'd9, 3, 10);
    run_frames("clean_release", 16'h0000, 3, 0, 4'd0, 1, 2);
    n_cmp++;
    if (key_code !== 4'd9) begin n_bad++; $display("FAIL clean_code_kept: got %0d want 9", key_code); end
  endtask

  task automatic test_bounce();
    keys = 16'h0000;
    do_reset();
    run_frames("bounce_a", 16'h0020, 1, 0, 4'd0, 99, 0);
    run_frames("bounce_gap", 16'h0000, 1, 0, 4'd0, 99, 0);
    run_frames("bounce_b", 16'h0020, 4, 3, 4'd5, 3, 4);
    run_frames("bounce_rel", 16'h0000, 3, 0, 4'd0, 1, 2);
  endtask

  task automatic test_ghost();
    keys = 16'h0000;
    do_reset();
    run_frames("ghost_pre", 16'h0200, 3, 3, 4'd9, 3, 3);
    run_frames("ghost_prerel", 16'h0000, 3, 0, 4'd0, 1, 2);
    run_frames("ghost", 16'h8001, 8, 0, 4'd0, 99, 0);
    n_cmp++;
    if (key_code !== 4'd9) begin n_bad++; $display("FAIL ghost_code_kept: got %0d want 9", key_code); end
  endtask

  task automatic test_rollover();
    keys = 16'h0000;
    do_reset();
    run_frames("roll_5", 16'h0020, 3, 3, 4'd5, 3, 3);
    run_frames("roll_56", 16'h0060, 4, 0, 4'd0, 1, 4);
    n_cmp++;
    if (key_code !== 4'd5) begin n_bad++; $display("FAIL roll_code_kept: got %0d want 5", key_code); end
    run_frames("roll_rel", 16'h0000, 3, 0, 4'd0, 1, 2);
    run_frames("roll_6", 16'h0040, 3, 3, 4'd6, 3, 3);
  endtask

  task automatic test_reset_mid();
    keys = 16'h0000;
    do_reset();
    run_frames("mid_deb", 16'h0200, 2, 0, 4'd0, 99, 0);
    // Abort during DEBOUNCE.
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    n_cmp++;
    if (key_valid !== 1'b0) begin n_bad++; $display("FAIL mid_deb_valid: got %b want 0", key_valid); end
    n_cmp++;
    if (col !== 4'b1110) begin n_bad++; $display("FAIL mid_deb_col: got %b want 1110", col); end
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    run_frames("mid_reacc", 16'h0200, 4, 3, 4'd9, 3, 4);
    // Abort during PRESSED; outputs must clear without waiting for a clock.
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    n_cmp++;
    if (key_held !== 1'b0) begin n_bad++; $display("FAIL mid_prs_held: got %b want 0", key_held); end
    n_cmp++;
    if (key_code !== 4'd0) begin n_bad++; $display("FAIL mid_prs_code: got %0d want 0", key_code); end
    n_cmp++;
    if (col !== 4'b1110) begin n_bad++; $display("FAIL mid_prs_col: got %b want 1110", col); end
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    run_frames("mid_reacc2", 16'h0200, 3, 3, 4'd9, 3, 3);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_ghost();
    test_rollover();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
